data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl_pkg.sv | 21 ++
 rtl/data_memory_ctrl_if.sv | 23 ++
 rtl/data_memory_ctrl_mem_line_array.sv | 39 +++
 rtl/data_memory_ctrl.sv | 104 ++++++++++
 tb/tb_data_memory_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and constants for the data memory controller.
package data_memory_ctrl_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 32;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Counter preload: the accept edge and the ACK-entry edge account for two
  // of the LATENCY cycles, so WAIT counts down the remaining LATENCY-2.
  function automatic logic [CNT_W-1:0] latency_load(input int unsigned latency);
    return CNT_W'(latency - 32'd2);
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the data cache (master) and the controller (slave).
interface data_memory_ctrl_if;
  import data_memory_ctrl_pkg::*;

  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic              busy_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, busy_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, busy_o
  );

endinterface

// File: rtl/data_memory_ctrl_mem_line_array.sv
// Single-port line storage: synchronous write, registered read port.
// The array itself is never reset; only the read register is.
module mem_line_array
  import data_memory_ctrl_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  // Line write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Read register holds the last read line until the next read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Fixed-latency line memory controller: one outstanding request, ack pulse
// LATENCY cycles after accept, memory access performed on the ACK-entry edge.
module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  data_memory_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ack_q, busy_q;
  logic              finish_s;
  logic              unused_s;

  // Offset bits and bits above the line index never affect the access.
  assign unused_s = ^{bus.addr_i[ADDR_W-1:OFFSET_W+IDX_W], bus.addr_i[OFFSET_W-1:0]};

  // The edge leaving WAIT is the edge that enters ACK.
  assign finish_s = (state_q == WAIT) && (cnt_q == '0);

  // State, counter and latched request registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ack_q   <= (state_d == ACK);
      busy_q  <= (state_d != IDLE);
    end
  end

  // Next-state logic; request inputs only matter in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          idx_d   = bus.addr_i[OFFSET_W +: IDX_W];
          wr_d    = bus.write_i;
          wdata_d = bus.data_i;
          cnt_d   = latency_load(LATENCY);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  mem_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (finish_s && wr_q),
    .re_i    (finish_s && !wr_q),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (bus.data_o)
  );

  assign bus.ack_o  = ack_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench: two controllers (LATENCY 10 and 2) share one stimulus
// path selected by sel_s; a scoreboard queue holds the data_o expected at each ack.
module tb_data_memory_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sel_s = 1'b0;
  logic         en_s = 1'b0;
  logic         wr_s = 1'b0;
  logic [31:0]  addr_s = 32'd0;
  logic [255:0] wdata_s = 256'd0;

  int vectors = 0;
  int miscompares = 0;

  logic [255:0] exp_q [$];
  logic [255:0] mdl [2][512];
  logic [255:0] last_rd [2];

  data_memory_ctrl_if bus0 ();
  data_memory_ctrl_if bus1 ();

  assign bus0.addr_i   = addr_s;
  assign bus0.data_i   = wdata_s;
  assign bus0.write_i  = wr_s;
  assign bus0.enable_i = en_s & ~sel_s;
  assign bus1.addr_i   = addr_s;
  assign bus1.data_i   = wdata_s;
  assign bus1.write_i  = wr_s;
  assign bus1.enable_i = en_s & sel_s;

  wire          ack_w  = sel_s ? bus1.ack_o  : bus0.ack_o;
  wire          busy_w = sel_s ? bus1.busy_o : bus0.busy_o;
  wire [255:0]  dout_w = sel_s ? bus1.data_o : bus0.data_o;

  data_memory_ctrl #(.LATENCY(10), .DEPTH(512)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus0)
  );

  data_memory_ctrl #(.LATENCY(2), .DEPTH(512)) dut2 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue what data_o must show at this transaction's ack and update the model.
  task automatic push_expect(input bit s, input logic [31:0] a, input logic [255:0] d, input bit w);
    int idx;
    idx = int'((a >> 5) & 32'd511);
    if (w) begin
      exp_q.push_back(last_rd[s]);
      mdl[s][idx] = d;
    end else begin
      exp_q.push_back(mdl[s][idx]);
      last_rd[s] = mdl[s][idx];
    end
  endtask

  // One request: pulse enable, optionally scramble inputs during WAIT,
  // check busy every cycle, ack latency, data_o at ack and return to IDLE.
  task automatic txn(input bit s, input logic [31:0] a, input logic [255:0] d,
                     input bit w, input bit scr);
    int lat;
    int lim;
    logic [255:0] e;
    lim = s ? 2 : 10;
    lat = 0;
    sel_s = s;
    push_expect(s, a, d, w);
    @(negedge clk);
    en_s = 1'b1; addr_s = a; wdata_s = d; wr_s = w;
    @(negedge clk);
    en_s = 1'b0;
    if (scr) begin
      addr_s = ~a; wdata_s = ~d; wr_s = ~w;
    end
    for (int c = 1; c <= 300; c++) begin
      if (c > 1) @(negedge clk);
      check("busy_during_req", {255'd0, busy_w}, 256'd1);
      if (ack_w) begin
        lat = c;
        break;
      end
    end
    check("ack_latency", 256'(lat), 256'(lim));
    e = exp_q.pop_front();
    check("data_at_ack", dout_w, e);
    @(negedge clk);
    check("ack_single_cycle", {255'd0, ack_w}, 256'd0);
    check("busy_after_ack", {255'd0, busy_w}, 256'd0);
    check("data_held", dout_w, last_rd[s]);
  endtask

  initial begin
    int cyc;
    int nacks;
    int prev;
    logic [255:0] e;
    last_rd[0] = 256'd0;
    last_rd[1] = 256'd0;

    // Reset state, both instances.
    #1;
    check("rst_ack0",  {255'd0, bus0.ack_o},  256'd0);
    check("rst_busy0", {255'd0, bus0.busy_o}, 256'd0);
    check("rst_data0", bus0.data_o, 256'd0);
    check("rst_ack1",  {255'd0, bus1.ack_o},  256'd0);
    check("rst_data1", bus1.data_o, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload line 3 and read it back through 0x60.
    txn(1'b0, 32'h0000_0060, {32{8'hA5}}, 1'b1, 1'b0);
    txn(1'b0, 32'h0000_0060, 256'd0, 1'b0, 1'b0);

    // Write then read 0x80; data_o must stay A5.. during the write.
    txn(1'b0, 32'h0000_0080, 256'h1234, 1'b1, 1'b0);
    txn(1'b0, 32'h0000_0080, 256'hFFFF, 1'b0, 1'b0);

    // Back-to-back reads with enable held high.
    sel_s = 1'b0;
    for (int k = 0; k < 3; k++) push_expect(1'b0, 32'h0000_0060, 256'd0, 1'b0);
    @(negedge clk);
    en_s = 1'b1; addr_s = 32'h0000_0060; wr_s = 1'b0; wdata_s = 256'd0;
    cyc = 0; nacks = 0; prev = 0;
    while (nacks < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack_w) begin
        nacks++;
        if (nacks == 1) check("b2b_first_ack", 256'(cyc), 256'd10);
        else            check("b2b_ack_gap", 256'(cyc - prev), 256'd11);
        prev = cyc;
        e = exp_q.pop_front();
        check("b2b_data", dout_w, e);
        if (nacks == 3) en_s = 1'b0;
      end
    end
    check("b2b_ack_count", 256'(nacks), 256'd3);
    @(negedge clk);
    check("b2b_no_double_accept", {255'd0, busy_w}, 256'd0);

    // Address wrap: 0x4000 is line 512 -> line 0.
    txn(1'b0, 32'h0000_4000, 256'hC0FFEE_0000_BEEF, 1'b1, 1'b0);
    txn(1'b0, 32'h0000_0000, 256'd0, 1'b0, 1'b0);
    txn(1'b0, 32'hFFF0_0060, 256'd0, 1'b0, 1'b0);

    // Inputs scrambled during WAIT must not affect the operation.
    txn(1'b0, 32'h0000_00A0, {8{32'h5A5A_0F0F}}, 1'b1, 1'b1);
    txn(1'b0, 32'h0000_00A0, 256'd0, 1'b0, 1'b1);

    // Minimum latency instance.
    txn(1'b1, 32'h0000_0020, 256'h0BAD_F00D, 1'b1, 1'b1);
    txn(1'b1, 32'h0000_0020, 256'd0, 1'b0, 1'b1);

    // Reset in the middle of a write to line 7.
    txn(1'b0, 32'h0000_00E0, 256'h7777_7777, 1'b1, 1'b0);
    sel_s = 1'b0;
    @(negedge clk);
    en_s = 1'b1; addr_s = 32'h0000_00E0; wdata_s = 256'hDEAD; wr_s = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      en_s = 1'b0;
      check("abort_no_early_ack", {255'd0, ack_w}, 256'd0);
    end
    rst_n = 1'b0;
    #1;
    check("abort_ack_low",  {255'd0, ack_w},  256'd0);
    check("abort_busy_low", {255'd0, busy_w}, 256'd0);
    check("abort_data_zero", dout_w, 256'd0);
    last_rd[0] = 256'd0;
    last_rd[1] = 256'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check("abort_ack_never", {255'd0, ack_w}, 256'd0);
    end
    txn(1'b0, 32'h0000_00E0, 256'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
